// File: rtl/ram_burst_ctrl_if.sv
// rtl/ram_burst_ctrl_if.sv - request, write-data, read-data and RAM pin bundle for ram_burst_ctrl
interface ram_burst_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int LW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          done;
  logic          busy;
  logic          ram_cs;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len,
    input  wdata_valid, wdata, rdata_ready, ram_dout,
    output req_ready, wdata_ready, rdata_valid, rdata, done, busy,
    output ram_cs, ram_wr, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len,
    output wdata_valid, wdata, rdata_ready, ram_dout,
    input  req_ready, wdata_ready, rdata_valid, rdata, done, busy,
    input  ram_cs, ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst sequencer for a 1024x8 asynchronous RAM
// Writes are framed setup/strobe so address and data are frozen whenever ram_wr is high.
module ram_burst_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input logic              clk,
  input logic              rst_n,
  ram_burst_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_SETUP,
    S_WR_STROBE,
    S_RD_RUN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cur_addr;
  logic [LW-1:0] r_beats_left;
  logic          r_ram_cs;
  logic          r_ram_wr;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic [DW-1:0] r_rdata;
  logic          r_rdata_valid;
  logic          r_done;
  logic          r_rd_final;

  state_t        w_state;
  logic [AW-1:0] w_cur_addr;
  logic [LW-1:0] w_beats_left;
  logic          w_ram_cs;
  logic          w_ram_wr;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din;
  logic [DW-1:0] w_rdata;
  logic          w_rdata_valid;
  logic          w_done;
  logic          w_rd_final;

  logic          w_req_ready;
  logic          w_req_fire;
  logic          w_rd_slot;
  logic          w_rd_hs;

  assign w_req_ready = (r_state == S_IDLE) & ~r_rdata_valid;
  assign w_req_fire  = io_bus.req_valid & w_req_ready;
  assign w_rd_slot   = ~r_rdata_valid | io_bus.rdata_ready;
  assign w_rd_hs     = r_rdata_valid & io_bus.rdata_ready;

  always_comb begin
    w_state       = r_state;
    w_cur_addr    = r_cur_addr;
    w_beats_left  = r_beats_left;
    w_ram_cs      = r_ram_cs;
    w_ram_wr      = r_ram_wr;
    w_ram_addr    = r_ram_addr;
    w_ram_din     = r_ram_din;
    w_rdata       = r_rdata;
    w_rdata_valid = r_rdata_valid;
    w_done        = 1'b0;
    w_rd_final    = r_rd_final;

    // Output slot drains first; a sample in RD_RUN below may refill it on the same edge.
    if (w_rd_hs) begin
      w_rdata_valid = 1'b0;
      w_rd_final    = 1'b0;
      if (r_rd_final) begin
        w_done = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_cur_addr   = io_bus.req_addr;
          w_beats_left = io_bus.req_len;
          if (io_bus.req_wr) begin
            w_state = S_WR_WAIT;
          end else begin
            w_state    = S_RD_RUN;
            w_ram_addr = io_bus.req_addr;
            w_ram_cs   = 1'b1;
            w_ram_wr   = 1'b0;
          end
        end
      end

      S_WR_WAIT: begin
        w_ram_cs = 1'b0;
        w_ram_wr = 1'b0;
        if (io_bus.wdata_valid) begin
          w_ram_din  = io_bus.wdata;
          w_ram_addr = r_cur_addr;
          w_ram_cs   = 1'b1;
          w_state    = S_WR_SETUP;
        end
      end

      S_WR_SETUP: begin
        w_ram_wr = 1'b1;
        w_state  = S_WR_STROBE;
      end

      S_WR_STROBE: begin
        w_ram_wr   = 1'b0;
        w_ram_cs   = 1'b0;
        w_cur_addr = r_cur_addr + 1'b1;
        if (r_beats_left == '0) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end else begin
          w_beats_left = r_beats_left - 1'b1;
          w_state      = S_WR_WAIT;
        end
      end

      S_RD_RUN: begin
        w_ram_cs = 1'b1;
        w_ram_wr = 1'b0;
        if (w_rd_slot) begin
          w_rdata       = io_bus.ram_dout;
          w_rdata_valid = 1'b1;
          w_ram_addr    = r_ram_addr + 1'b1;
          w_cur_addr    = r_cur_addr + 1'b1;
          if (r_beats_left == '0) begin
            w_ram_cs   = 1'b0;
            w_rd_final = 1'b1;
            w_state    = S_IDLE;
          end else begin
            w_beats_left = r_beats_left - 1'b1;
          end
        end
      end

      default: begin
        w_state  = S_IDLE;
        w_ram_cs = 1'b0;
        w_ram_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_ram_cs      <= 1'b0;
      r_ram_wr      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_rd_final    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cur_addr    <= w_cur_addr;
      r_beats_left  <= w_beats_left;
      r_ram_cs      <= w_ram_cs;
      r_ram_wr      <= w_ram_wr;
      r_ram_addr    <= w_ram_addr;
      r_ram_din     <= w_ram_din;
      r_rdata       <= w_rdata;
      r_rdata_valid <= w_rdata_valid;
      r_done        <= w_done;
      r_rd_final    <= w_rd_final;
    end
  end

  assign io_bus.req_ready   = w_req_ready;
  assign io_bus.wdata_ready = (r_state == S_WR_WAIT);
  assign io_bus.busy        = (r_state != S_IDLE);
  assign io_bus.rdata       = r_rdata;
  assign io_bus.rdata_valid = r_rdata_valid;
  assign io_bus.done        = r_done;
  assign io_bus.ram_cs      = r_ram_cs;
  assign io_bus.ram_wr      = r_ram_wr;
  assign io_bus.ram_addr    = r_ram_addr;
  assign io_bus.ram_din     = r_ram_din;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - scoreboard bench for ram_burst_ctrl with an asynchronous RAM model
module tb_ram_burst_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

  ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  logic [DW-1:0] tb_mem  [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  assign bus.ram_dout = (bus.ram_cs && !bus.ram_wr) ? tb_mem[bus.ram_addr] : 'x;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  int               strobe_cyc[$];
  logic [DW-1:0]    wq[$];
  int done_exp = 0;
  int done_seen = 0;
  int last_done_cyc = 0;
  int rdy_mode = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Consumer side: rdata_ready pattern selected by rdy_mode.
  initial begin
    int k;
    k = 0;
    bus.rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (rdy_mode)
        0:       bus.rdata_ready = 1'b1;
        1:       bus.rdata_ready = (k % 3 == 0);
        default: bus.rdata_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard and RAM write model.
  logic          p_cs = 1'b0, p_wr = 1'b0, p_rv = 1'b0, p_rr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_din = '0;
  initial begin
    logic [AW+DW-1:0] ew;
    logic [DW-1:0]    er;
    forever begin
      @(negedge clk);
      if (bus.ram_cs && bus.ram_wr) tb_mem[bus.ram_addr] = bus.ram_din;
      if (rst_n) begin
        if (exp_rd.size() > 0) check("req_ready_while_read_pending", 32'(bus.req_ready), 32'd0);
        if (bus.rdata_valid && bus.rdata_ready) begin
          if (exp_rd.size() == 0) begin
            check("unexpected_rdata", 32'(bus.rdata), 32'hFFFF_FFFF);
          end else begin
            er = exp_rd.pop_front();
            check("rdata", 32'(bus.rdata), 32'(er));
          end
        end
        if (bus.ram_cs && bus.ram_wr) begin
          strobe_cyc.push_back(cyc);
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 32'({bus.ram_addr, bus.ram_din}), 32'hFFFF_FFFF);
          end else begin
            ew = exp_wr.pop_front();
            check("write_addr_data", 32'({bus.ram_addr, bus.ram_din}), 32'(ew));
          end
          check("strobe_single_cycle", 32'(p_wr), 32'd0);
          check("setup_stable", 32'({p_cs, p_addr, p_din}), 32'({1'b1, bus.ram_addr, bus.ram_din}));
        end
        if (p_wr && !bus.ram_wr)
          check("hold_stable", 32'({bus.ram_addr, bus.ram_din}), 32'({p_addr, p_din}));
        if (p_cs && !p_wr && p_rv && !p_rr && bus.ram_cs)
          check("addr_frozen_on_stall", 32'(bus.ram_addr), 32'(p_addr));
        if (bus.wdata_ready)
          check("idle_pins_in_wr_wait", 32'({bus.ram_cs, bus.ram_wr}), 32'd0);
        if (bus.done) begin
          done_seen++;
          last_done_cyc = cyc;
        end
      end
      p_cs = bus.ram_cs; p_wr = bus.ram_wr; p_rv = bus.rdata_valid; p_rr = bus.rdata_ready;
      p_addr = bus.ram_addr; p_din = bus.ram_din;
    end
  end

  task automatic issue_req(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           output int acc);
    int t;
    t = 0;
    while (!bus.req_ready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 1000) check("req_ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(posedge clk); #1;
    acc = cyc;
    bus.req_valid = 1'b0;
    bus.req_addr  = AW'($urandom);
    bus.req_len   = LW'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((done_seen < done_exp || exp_rd.size() > 0) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check("burst_completion", 32'(done_seen), 32'(done_exp));
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int len, input int gap, output int acc);
    logic [AW-1:0] a;
    int t;
    for (int i = 0; i <= len; i++) begin
      a = addr + AW'(i);
      ref_mem[a] = wq[i];
      exp_wr.push_back({a, wq[i]});
    end
    done_exp++;
    issue_req(1'b1, addr, LW'(len), acc);
    for (int i = 0; i <= len; i++) begin
      if (gap > 0 && i > 0) begin
        bus.wdata_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      bus.wdata_valid = 1'b1;
      bus.wdata = wq[i];
      t = 0;
      while (!bus.wdata_ready && t < 1000) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 1000) check("wdata_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    bus.wdata_valid = 1'b0;
    wait_done();
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len, output int acc);
    logic [DW-1:0] vals[$];
    for (int i = 0; i <= len; i++) vals.push_back(ref_mem[addr + AW'(i)]);
    issue_req(1'b0, addr, LW'(len), acc);
    for (int i = 0; i <= len; i++) exp_rd.push_back(vals[i]);
    done_exp++;
    @(posedge clk); #1;
    check("first_rdata_latency", 32'(bus.rdata_valid), 32'd1);
    wait_done();
  endtask

  initial begin
    int acc;
    int rst_cyc;
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins", 32'({bus.ram_cs, bus.ram_wr, bus.rdata_valid, bus.done, bus.busy}), 32'd0);
    check("reset_addr_din_rdata", 32'({bus.ram_addr, bus.ram_din, bus.rdata}), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed write burst with wdata_valid held high.
    wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    strobe_cyc.delete();
    write_burst(10'h010, 3, 0, acc);
    check("wr_strobe_count", 32'(strobe_cyc.size()), 32'd4);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("wr_strobe_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd3);
    check("wr_done_timing", 32'(last_done_cyc - acc), 32'd12);

    read_burst(10'h010, 3, acc);
    check("rd_done_timing", 32'(last_done_cyc - acc), 32'd5);

    // Address wrap at the top of the RAM.
    wq = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_burst(10'h3FE, 3, 0, acc);
    read_burst(10'h3FE, 3, acc);

    // Read backpressure 1,0,0 pattern.
    rdy_mode = 1;
    read_burst(10'h010, 3, acc);
    rdy_mode = 0;

    // Write data stalls between beats.
    wq = '{8'h5A, 8'hC3, 8'h96, 8'h0F};
    write_burst(10'h100, 3, 5, acc);
    read_burst(10'h100, 3, acc);

    // Reset during the setup cycle of the second write beat.
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    ref_mem[10'h200] = wq[0];
    exp_wr.push_back({10'h200, wq[0]});
    issue_req(1'b1, 10'h200, 8'd3, acc);
    bus.wdata_valid = 1'b1;
    bus.wdata = wq[0];
    @(posedge clk); #1;
    bus.wdata = wq[1];
    repeat (3) begin @(posedge clk); #1; end
    check("beat2_in_setup", 32'({bus.ram_cs, bus.ram_wr, bus.ram_din}), 32'({1'b1, 1'b0, wq[1]}));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_cyc = cyc;
    check("midburst_reset_pins", 32'({bus.ram_cs, bus.ram_wr, bus.rdata_valid, bus.done, bus.busy}), 32'd0);
    check("midburst_reset_regs", 32'({bus.ram_addr, bus.ram_din, bus.rdata}), 32'd0);
    check("midburst_reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    bus.wdata_valid = 1'b0;
    read_burst(10'h200, 3, acc);
    check("accept_after_reset", 32'(acc - rst_cyc), 32'd1);

    // Randomized bursts against the reference memory.
    for (int n = 0; n < 24; n++) begin
      logic [AW-1:0] a;
      int len;
      a = AW'($urandom);
      len = int'($urandom_range(0, 15));
      rdy_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i <= len; i++) wq.push_back(DW'($urandom));
        write_burst(a, len, int'($urandom_range(0, 3)), acc);
      end else begin
        read_burst(a, len, acc);
      end
    end
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;

    check("leftover_reads", 32'(exp_rd.size()), 32'd0);
    check("leftover_writes", 32'(exp_wr.size()), 32'd0);
    check("done_total", 32'(done_seen), 32'(done_exp));
    n_assert++;
    for (int i = 0; i < 1024; i++) begin
      if (tb_mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL ram_contents[0x%0h]: got 0x%0h expected 0x%0h", i, tb_mem[i], ref_mem[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Sequencer that sits directly upstream of the 1024x8 asynchronous RAM. It turns valid/ready burst requests into ram_cs/ram_wr/ram_addr/ram_din pulses, with auto-incrementing addresses. It returns read data over a valid/ready stream. The write strobe is framed so that address and data never change while ram_wr is high, because the RAM writes combinationally whenever cs and wr are both high.

Parameters:
AW, 10, RAM address width
DW, 8, data width
LW, 8, burst length field width; beats per burst = req_len+1 (1..256)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge
req_valid  in  1  burst request valid
req_ready  out  1  controller can accept a request
req_wr  in  1  1=write burst, 0=read burst
req_addr  in  AW  start address
req_len  in  LW  beats minus one
wdata_valid  in  1  write data valid
wdata_ready  out  1  write data accepted this cycle
wdata  in  DW  write data
rdata_valid  out  1  read data valid
rdata_ready  in  1  consumer accepts read data
rdata  out  DW  read data
done  out  1  one-cycle pulse when a burst completes
busy  out  1  high in any state other than IDLE
ram_cs  out  1  RAM chip select
ram_wr  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data; high-Z unless ram_cs=1 and ram_wr=0

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; ram_cs, ram_wr, rdata_valid, done = 0; ram_addr, ram_din, rdata = 0; beat counter = 0.
- Registered outputs: ram_cs, ram_wr, ram_addr, ram_din, rdata, rdata_valid, done.
- Combinational outputs: req_ready = (state==IDLE) & ~rdata_valid; wdata_ready = (state==WR_WAIT); busy = (state!=IDLE).
- States: IDLE, WR_WAIT, WR_SETUP, WR_STROBE, RD_RUN.
- IDLE: on req_valid & req_ready, latch cur_addr=req_addr and beats_left=req_len.
  - If req_wr=1, go to WR_WAIT.
  - If req_wr=0, go to RD_RUN and set ram_addr=req_addr, ram_cs=1, ram_wr=0.
- WR_WAIT: ram_cs=0, ram_wr=0. On wdata_valid, register ram_din=wdata and ram_addr=cur_addr, set ram_cs=1 (ram_wr stays 0), go to WR_SETUP.
- WR_SETUP: one cycle with address and data stable. Next edge: ram_wr=1, go to WR_STROBE.
- WR_STROBE: exactly one cycle with ram_wr=1. Next edge: ram_wr=0, ram_cs=0, cur_addr+1.
  - If beats_left==0: go to IDLE and pulse done.
  - Otherwise: decrement beats_left and go to WR_WAIT.
- Write timing: minimum 3 cycles per beat. ram_addr and ram_din are never updated on an edge where ram_wr is high before or after that edge.
- RD_RUN: ram_cs=1, ram_wr=0. ram_dout is sampled at the end of the cycle only when the output slot is free (~rdata_valid | rdata_ready).
  - On sample: rdata=ram_dout, rdata_valid=1, ram_addr+1.
  - On the final sample: ram_cs=0, go to IDLE.
  - With no backpressure, throughput is 1 beat/cycle. First rdata is valid one cycle after request acceptance.
- rdata_valid clears on rdata_ready when no new sample is taken.
- done for a read burst pulses in the cycle after the final beat's rdata handshake.
- Address wraps modulo 2^AW: 1023+1 = 0. beats_left does not wrap.
- A new request is not accepted while the final read beat is still pending (req_ready=0).
- Reset mid-burst: next edge returns to IDLE with ram_cs=ram_wr=0. The remaining beats are dropped. A write strobe already completed is retained; no partial or extra strobe is generated.
- req_* inputs are ignored outside IDLE. wdata is ignored outside WR_WAIT.

Test Plan:
1. Write burst: req_addr=0x010, req_len=3, wdata 0xA1,0xA2,0xA3,0xA4 with wdata_valid held high -> exactly 4 single-cycle ram_wr pulses at addresses 0x010..0x013, 3 cycles apart; done pulses once; RAM holds those values.
2. Read-back of scenario 1 with rdata_ready=1 -> rdata 0xA1..0xA4 on consecutive cycles, first one cycle after acceptance; done pulses after the 4th handshake.
3. Wrap: write req_addr=0x3FE, req_len=3, data 1,2,3,4 -> locations 0x3FE,0x3FF,0x000,0x001 written; read-back matches.
4. Backpressure: read 4 beats with rdata_ready toggling 1,0,0,1,... -> no beat lost or duplicated; ram_addr advances only on samples; req_ready stays 0 until the last beat is consumed.
5. wdata stall: write burst with wdata_valid low for 5 cycles between beats -> ram_cs=ram_wr=0 throughout the stall; no spurious write occurs.
6. Reset in WR_SETUP of beat 2 of a 4-beat write -> beat 1 is written, beats 2-4 are not; outputs are at reset values after the edge; a new request is accepted the cycle after rst_n returns high.
